// File: rtl/ro_window_counter.sv
// Ring-oscillator window counter: steps the RO mux select through every sensor,
// discards a settle interval, counts synchronized RO rising edges over a fixed window
// and hands {index, count} to the readout over a valid/ready handshake.

module ro_window_counter #(
    parameter int NWAY          = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 4096,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    output logic [10:0]      select,
    input  logic             ro_selected,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [10:0]      result_idx,
    output logic [CNT_W-1:0] result_count,
    output logic             busy,
    output logic             sweep_done
);

    localparam int IDX_W = 11;
    localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int WC_W  = $clog2(WINDOW_CYCLES + 1);

    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [WC_W-1:0]  WINDOW_LAST = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NWAY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    state_t            state_r;
    logic              sync1_r;
    logic              sync2_r;
    logic              sync3_r;
    logic              rise_s;
    logic [SC_W-1:0]   settle_cnt_r;
    logic [WC_W-1:0]   window_cnt_r;
    logic [CNT_W-1:0]  edge_cnt_r;
    logic [CNT_W-1:0]  edge_cnt_next_s;
    logic [IDX_W-1:0]  idx_r;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end else begin
            return cnt;
        end
    endfunction

    assign rise_s          = sync2_r & ~sync3_r;
    assign edge_cnt_next_s = sat_inc(edge_cnt_r, rise_s);

    // Two-flop synchronizer for the asynchronous RO plus one history flop for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= ro_selected;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Sweep sequencer: state, counters, sensor index and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= SC_W'(0);
            window_cnt_r <= WC_W'(0);
            edge_cnt_r   <= CNT_W'(0);
            idx_r        <= IDX_W'(0);
            select       <= IDX_W'(0);
            result_valid <= 1'b0;
            result_idx   <= IDX_W'(0);
            result_count <= CNT_W'(0);
            busy         <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_SETTLE;
                        idx_r        <= IDX_W'(0);
                        select       <= IDX_W'(0);
                        settle_cnt_r <= SC_W'(0);
                        edge_cnt_r   <= CNT_W'(0);
                        busy         <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    // Edges seen here still carry the previous sensor's history.
                    edge_cnt_r <= CNT_W'(0);
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r      <= ST_MEASURE;
                        settle_cnt_r <= SC_W'(0);
                        window_cnt_r <= WC_W'(0);
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SC_W'(1);
                    end
                end
                ST_MEASURE: begin
                    edge_cnt_r <= edge_cnt_next_s;
                    if (window_cnt_r == WINDOW_LAST) begin
                        state_r      <= ST_OUTPUT;
                        window_cnt_r <= WC_W'(0);
                        result_count <= edge_cnt_next_s;
                        result_idx   <= idx_r;
                        result_valid <= 1'b1;
                    end else begin
                        window_cnt_r <= window_cnt_r + WC_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        settle_cnt_r <= SC_W'(0);
                        edge_cnt_r   <= CNT_W'(0);
                        if (idx_r == IDX_LAST) begin
                            sweep_done <= 1'b1;
                            idx_r      <= IDX_W'(0);
                            select     <= IDX_W'(0);
                            if (continuous) begin
                                state_r <= ST_SETTLE;
                            end else begin
                                state_r <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            select  <= idx_r + IDX_W'(1);
                            state_r <= ST_SETTLE;
                        end
                    end else begin
                        state_r <= ST_OUTPUT;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_window_counter.sv
// Randomized bench for ro_window_counter: two instances (5-way/16-bit and 1-way/4-bit)
// checked against a timeline model that counts rising edges in the recorded RO samples.

module tb_ro_window_counter;

    localparam int S    = 16;
    localparam int W    = 100;
    localparam int NA   = 5;
    localparam int NB   = 1;
    localparam int HMAX = 30000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ro = 1'b0;
    logic        start_a = 1'b0, cont_a = 1'b0, ready_a = 1'b0;
    logic        start_b = 1'b0, cont_b = 1'b0, ready_b = 1'b0;
    logic [10:0] sel_a, idx_a, sel_b, idx_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic        rv_a, busy_a, done_a, rv_b, busy_b, done_b;

    int   cyc = 0;
    logic hist [HMAX];
    int   errors = 0;
    int   checks = 0;
    int   mode = 0;
    int   period = 10;
    int   stop_cyc = 0;

    ro_window_counter #(.NWAY(NA), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .select(sel_a),
        .ro_selected(ro), .result_valid(rv_a), .result_ready(ready_a), .result_idx(idx_a),
        .result_count(cnt_a), .busy(busy_a), .sweep_done(done_a));

    ro_window_counter #(.NWAY(NB), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .select(sel_b),
        .ro_selected(ro), .result_valid(rv_b), .result_ready(ready_b), .result_idx(idx_b),
        .result_count(cnt_b), .busy(busy_b), .sweep_done(done_b));

    always #5 clk = ~clk;

    // Record the RO level seen at every rising clock edge, indexed by edge number.
    always @(posedge clk) begin
        if (cyc < HMAX) hist[cyc] <= ro;
        cyc <= cyc + 1;
    end

    // RO waveform generator; changes only on the falling edge so every sample is unambiguous.
    always @(negedge clk) begin
        case (mode)
            1: ro <= ((cyc % period) < (period / 2));
            2: if ($urandom_range(0, 2) == 0) ro <= ~ro;
            3: ro <= (cyc < stop_cyc) ? cyc[0] : 1'b0;
            default: ro <= 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] g_valid(bit b); return b ? 32'(rv_b)   : 32'(rv_a);   endfunction
    function automatic logic [31:0] g_idx(bit b);   return b ? 32'(idx_b)  : 32'(idx_a);  endfunction
    function automatic logic [31:0] g_cnt(bit b);   return b ? 32'(cnt_b)  : 32'(cnt_a);  endfunction
    function automatic logic [31:0] g_sel(bit b);   return b ? 32'(sel_b)  : 32'(sel_a);  endfunction
    function automatic logic [31:0] g_busy(bit b);  return b ? 32'(busy_b) : 32'(busy_a); endfunction
    function automatic logic [31:0] g_done(bit b);  return b ? 32'(done_b) : 32'(done_a); endfunction

    // Window opens S edges after the anchor edge and lasts W edges; each counted edge
    // reflects a 0->1 step in the samples taken two and three edges earlier.
    function automatic int expected_count(int anchor, int maxv);
        int c = 0;
        for (int p = anchor + S + 1; p <= anchor + S + W; p++) begin
            if (hist[p-2] === 1'b1 && hist[p-3] === 1'b0) c++;
        end
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic set_ready(bit b, logic v);
        if (b) ready_b = v; else ready_a = v;
    endtask

    task automatic set_start(bit b, logic v);
        if (b) start_b = v; else start_a = v;
    endtask

    task automatic check_reset(bit b);
        check("rst_select", g_sel(b), 0);
        check("rst_valid", g_valid(b), 0);
        check("rst_idx", g_idx(b), 0);
        check("rst_count", g_cnt(b), 0);
        check("rst_busy", g_busy(b), 0);
        check("rst_done", g_done(b), 0);
    endtask

    task automatic do_start(bit b, output int anchor);
        @(negedge clk);
        set_start(b, 1'b1);
        @(posedge clk);
        #1;
        anchor = cyc - 1;
        set_start(b, 1'b0);
        check("start_busy", g_busy(b), 1);
        check("start_select", g_sel(b), 0);
    endtask

    task automatic set_stim(int anchor, int force_p);
        if (force_p != 0) begin
            mode   = 1;
            period = force_p;
        end else begin
            mode   = $urandom_range(1, 3);
            period = $urandom_range(2, 12);
        end
        stop_cyc = anchor + S - 1;
    endtask

    task automatic wait_result(bit b, int anchor, int exp_idx, int maxv);
        int n = 0;
        while (g_valid(b) !== 32'd1 && n < S + W + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_rise", g_valid(b), 1);
        check("latency", cyc - 1, anchor + S + W);
        check("result_idx", g_idx(b), exp_idx);
        check("result_count", g_cnt(b), expected_count(anchor, maxv));
        check("select_meas", g_sel(b), exp_idx);
        check("busy_meas", g_busy(b), 1);
        if (mode == 3) check("settle_only_count", g_cnt(b), 0);
    endtask

    task automatic accept(bit b, int nway, int exp_idx, bit cont, output int a);
        int st;
        bit last;
        logic [31:0] c0;
        st   = $urandom_range(0, 3);
        last = (exp_idx == nway - 1);
        c0   = g_cnt(b);
        repeat (st) begin
            @(negedge clk);
            set_ready(b, 1'b0);
            @(posedge clk);
            #1;
            check("stall_valid", g_valid(b), 1);
            check("stall_count", g_cnt(b), c0);
        end
        @(negedge clk);
        set_ready(b, 1'b1);
        if (last && !cont) set_start(b, 1'b1);
        @(posedge clk);
        #1;
        a = cyc - 1;
        set_start(b, 1'b0);
        check("acc_valid", g_valid(b), 0);
        check("acc_done", g_done(b), last ? 1 : 0);
        check("acc_select", g_sel(b), last ? 0 : exp_idx + 1);
        check("acc_busy", g_busy(b), (!last || cont) ? 1 : 0);
        if (last) begin
            @(posedge clk);
            #1;
            check("done_one_cycle", g_done(b), 0);
        end
    endtask

    task automatic run_sweep(bit b, int nway, int maxv, int anchor_in, bit cont, bit hold,
                             int force_p, int fixed, output int a_out);
        int anchor;
        int a;
        logic [31:0] c0;
        anchor = anchor_in;
        if (b) cont_b = cont; else cont_a = cont;
        for (int i = 0; i < nway; i++) begin
            set_stim(anchor, force_p);
            if (hold && i == 0) set_ready(b, 1'b0);
            if (i == 1) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                set_start(b, 1'b1);
                @(negedge clk);
                set_start(b, 1'b0);
            end
            wait_result(b, anchor, i, maxv);
            if (fixed >= 0) check("fixed_count", g_cnt(b), fixed);
            if (hold && i == 0) begin
                c0 = g_cnt(b);
                repeat (50) begin
                    @(posedge clk);
                    #1;
                    check("hold_valid", g_valid(b), 1);
                    check("hold_idx", g_idx(b), 0);
                    check("hold_count", g_cnt(b), c0);
                    check("hold_select", g_sel(b), 0);
                end
            end
            accept(b, nway, i, cont, a);
            anchor = a;
        end
        a_out = anchor;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int anc;
        int a;
        repeat (3) @(posedge clk);
        #1;
        check_reset(1'b0);
        check_reset(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Period-10 RO on every sensor, first result held 50 cycles.
        do_start(1'b0, anc);
        run_sweep(1'b0, NA, 65535, anc, 1'b0, 1'b1, 10, 10, a);
        repeat (20) @(posedge clk);
        #1;
        check("idle_valid", g_valid(1'b0), 0);
        check("idle_busy", g_busy(1'b0), 0);

        // Randomized sweep.
        do_start(1'b0, anc);
        run_sweep(1'b0, NA, 65535, anc, 1'b0, 1'b0, 0, -1, a);

        // Continuous: second sweep starts without start, then drops back to idle.
        do_start(1'b0, anc);
        run_sweep(1'b0, NA, 65535, anc, 1'b1, 1'b0, 0, -1, a);
        run_sweep(1'b0, NA, 65535, a, 1'b0, 1'b0, 0, -1, a);

        // Reset during MEASURE of index 2, then a fresh sweep from index 0.
        do_start(1'b0, anc);
        for (int i = 0; i < 2; i++) begin
            set_stim(anc, 0);
            wait_result(1'b0, anc, i, 65535);
            accept(1'b0, NA, i, 1'b0, anc);
        end
        repeat (S + 20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_valid", g_valid(1'b0), 0);
        check("post_rst_busy", g_busy(1'b0), 0);
        do_start(1'b0, anc);
        run_sweep(1'b0, NA, 65535, anc, 1'b0, 1'b0, 0, -1, a);

        // Single-sensor, 4-bit counter: period-4 RO saturates at 15; sweep_done on each accept.
        do_start(1'b1, anc);
        run_sweep(1'b1, NB, 15, anc, 1'b1, 1'b0, 4, 15, a);
        run_sweep(1'b1, NB, 15, a, 1'b0, 1'b0, 0, -1, a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
